// File: rtl/huffman_bit_packer.sv
// Packs 1..MAX_LEN-bit codewords MSB-first into bytes, with zero-padded flush.
// Optional HUFF_PACK_STATS_EN adds a 16-bit emitted-byte counter port.
module huffman_bit_packer #(
  parameter int unsigned MAX_LEN = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MAX_LEN-1:0] code_in,
  input  logic [3:0]         len_in,
  input  logic               code_valid,
  input  logic               flush,
  output logic [7:0]         out,
  output logic               valid,
  output logic               busy,
  output logic               flush_done,
  output logic               err
`ifdef HUFF_PACK_STATS_EN
  ,
  output logic [15:0]        byte_count
`endif
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0] MAX_L4 = 4'(MAX_LEN);

  state_t      state_q, state_d;
  logic [15:0] acc_q, acc_d, acc_n;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  add_len, n;
  logic [15:0] code_ext, mask;
  logic [4:0]  shamt;
  logic [7:0]  out_d;
  logic        valid_d, done_d, err_d, accept;

  assign busy = (state_q == FLUSH);

  always_comb begin
    accept   = code_valid && (len_in != 4'd0) && (len_in <= MAX_L4);
    add_len  = accept ? len_in : '0;
    n        = cnt_q + add_len;
    code_ext = 16'(code_in);
    mask     = (16'd1 << len_in) - 16'd1;
    shamt    = 5'd16 - {1'b0, n};
    // Bits below the fill point are always zero, so OR-ing the aligned codeword appends it.
    acc_n    = accept ? (acc_q | ((code_ext & mask) << shamt)) : acc_q;

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out;
    valid_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err;

    if (state_q == FLUSH) begin
      out_d   = acc_q[15:8];
      valid_d = 1'b1;
      done_d  = 1'b1;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = RUN;
    end else begin
      if (code_valid && (len_in > MAX_L4)) err_d = 1'b1;
      if (n >= 4'd8) begin
        out_d   = acc_n[15:8];
        valid_d = 1'b1;
        acc_d   = {acc_n[7:0], 8'h00};
        cnt_d   = n - 4'd8;
      end else begin
        acc_d = acc_n;
        cnt_d = n;
      end
      if (flush) begin
        if (n >= 4'd9) begin
          state_d = FLUSH;
        end else begin
          done_d = 1'b1;
          acc_d  = '0;
          cnt_d  = '0;
          if ((n != 4'd0) && (n < 4'd8)) begin
            out_d   = acc_n[15:8];
            valid_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      acc_q      <= '0;
      cnt_q      <= '0;
      out        <= '0;
      valid      <= 1'b0;
      flush_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out        <= out_d;
      valid      <= valid_d;
      flush_done <= done_d;
      err        <= err_d;
    end
  end

`ifdef HUFF_PACK_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         byte_count <= '0;
    else if (valid_d) byte_count <= byte_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Self-checking bench for huffman_bit_packer: directed cases plus random codewords
// compared against a bit-queue model of the packed stream.
module tb_huffman_bit_packer;

  localparam int unsigned ML = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] code_in = '0;
  logic [3:0] len_in = '0;
  logic       code_valid = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] out;
  logic       valid, busy, flush_done, err;
`ifdef HUFF_PACK_STATS_EN
  logic [15:0] byte_count;
`endif

  huffman_bit_packer #(.MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .len_in(len_in),
    .code_valid(code_valid), .flush(flush), .out(out), .valid(valid),
    .busy(busy), .flush_done(flush_done), .err(err)
`ifdef HUFF_PACK_STATS_EN
    , .byte_count(byte_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pending stream bits in transmission order.
  bit          mq[$];
  logic [7:0]  m_out;
  logic        m_pend, m_err, exp_valid, exp_done;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_out = '0; m_pend = 1'b0; m_err = 1'b0;
    exp_valid = 1'b0; exp_done = 1'b0; m_cnt = '0;
  endtask

  task automatic take_byte(output logic [7:0] b);
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b = b << 1;
      if (mq.size() > 0) b[0] = mq.pop_front();
    end
  endtask

  task automatic model_step(input logic cv, input logic [7:0] code,
                            input logic [3:0] len, input logic fl);
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    if (m_pend) begin
      take_byte(m_out);
      exp_valid = 1'b1; exp_done = 1'b1; m_pend = 1'b0;
    end else begin
      if (cv) begin
        if (int'(len) > int'(ML)) m_err = 1'b1;
        else for (int i = int'(len) - 1; i >= 0; i--) mq.push_back(code[i]);
      end
      if (mq.size() >= 8) begin
        take_byte(m_out);
        exp_valid = 1'b1;
      end
      if (fl) begin
        if (exp_valid && mq.size() > 0) m_pend = 1'b1;
        else begin
          exp_done = 1'b1;
          if (!exp_valid && mq.size() > 0) begin
            take_byte(m_out);
            exp_valid = 1'b1;
          end
        end
      end
    end
    if (exp_valid) m_cnt = m_cnt + 16'd1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 16'(valid), 16'(exp_valid));
    chk({tag, ".out"}, 16'(out), 16'(m_out));
    chk({tag, ".flush_done"}, 16'(flush_done), 16'(exp_done));
    chk({tag, ".busy"}, 16'(busy), 16'(m_pend));
    chk({tag, ".err"}, 16'(err), 16'(m_err));
`ifdef HUFF_PACK_STATS_EN
    chk({tag, ".byte_count"}, byte_count, m_cnt);
`endif
  endtask

  task automatic step(input string tag, input logic cv, input logic [7:0] code,
                      input logic [3:0] len, input logic fl);
    code_valid = cv; code_in = code; len_in = len; flush = fl;
    @(posedge clk);
    #1;
    model_step(cv, code, len, fl);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    #1;
    check_all(tag);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset("reset");

    step("basic0", 1'b1, 8'b101, 4'd3, 1'b0);
    step("basic1", 1'b1, 8'b11110, 4'd5, 1'b0);
    chk("basic_byte", 16'(out), 16'h00BE);
    step("hold", 1'b0, 8'h00, 4'd0, 1'b0);

    step("flush1", 1'b1, 8'h01, 4'd1, 1'b1);
    chk("flush1_byte", 16'(out), 16'h0080);
    step("flush1_idle", 1'b0, 8'h00, 4'd0, 1'b0);

    step("two0", 1'b1, 8'h55, 4'd7, 1'b0);
    step("two1", 1'b1, 8'hFF, 4'd8, 1'b1);
    chk("two_first", 16'(out), 16'h00AB);
    step("two2", 1'b1, 8'hFF, 4'd8, 1'b0);
    chk("two_second", 16'(out), 16'h00FE);
    step("two_idle", 1'b0, 8'h00, 4'd0, 1'b0);

    step("empty_flush", 1'b0, 8'h00, 4'd0, 1'b1);
    step("len0", 1'b1, 8'hFF, 4'd0, 1'b0);

    step("illegal", 1'b1, 8'hFF, 4'd9, 1'b0);
    step("after_ill", 1'b1, 8'h3C, 4'd8, 1'b0);
    chk("after_ill_byte", 16'(out), 16'h003C);

    step("mid0", 1'b1, 8'h1F, 4'd5, 1'b0);
    flush = 1'b1; code_valid = 1'b0;
    do_reset("mid_reset");
    step("mid1", 1'b1, 8'h3C, 4'd8, 1'b0);
    chk("mid_byte", 16'(out), 16'h003C);

    for (int k = 0; k < 3000; k++) begin
      logic       cv, fl;
      logic [3:0] ln;
      logic [7:0] cd;
      cv = ($urandom_range(0, 3) != 0);
      ln = ($urandom_range(0, 63) == 0) ? 4'(9 + $urandom_range(0, 6)) : 4'($urandom_range(0, 8));
      cd = 8'($urandom);
      fl = ($urandom_range(0, 7) == 0);
      step("rand", cv, cd, ln, fl);
    end

`ifdef HUFF_PACK_STATS_EN
    do_reset("stats_reset");
    for (int k = 0; k < 65536; k++) step("stats", 1'b1, 8'($urandom), 4'd8, 1'b0);
    chk("stats_wrap", byte_count, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/huffman_bit_packer.md
# huffman_bit_packer

Upstream feeder for the Huffman decoder. It accepts variable-length codewords (1..MAX_LEN bits) from the encoder side and packs them MSB-first into a continuous bitstream. It emits complete bytes on the 8-bit `out`/`valid` port, which connects directly to the decoder's `in`/`valid` inputs. A flush request pads the final partial byte with zeros and emits it.

## Interface
- `MAX_LEN`, default 8: maximum codeword length in bits; legal range 1..8.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous active-low reset.
- `code_in`  input  MAX_LEN  codeword. Bits `[len_in-1:0]` are significant, and bit `len_in-1` is transmitted first. Upper bits are ignored.
- `len_in`  input  4  codeword length. 0 means no codeword this cycle.
- `code_valid`  input  1  `code_in`/`len_in` are presented this cycle.
- `flush`  input  1  one-cycle request to pad and emit all buffered bits.
- `out`  output  8  packed byte; bit 7 is the earliest stream bit.
- `valid`  output  1  `out` holds a new byte; one-cycle pulse per byte.
- `busy`  output  1  high in FLUSH state; inputs are ignored while high.
- `flush_done`  output  1  one-cycle pulse when a flush has completed.
- `err`  output  1  sticky flag: a codeword with `len_in > MAX_LEN` was received. Cleared only by reset.

## Operation
- **State**
  - 16-bit accumulator `acc`, left-aligned.
  - Fill count `cnt`, 0..15 (held at ≤ 7 between cycles in RUN).
  - FSM with two states: RUN and FLUSH.
- **Accept rule (RUN)**
  - If `code_valid` is high and 1 ≤ `len_in` ≤ MAX_LEN, append `len_in` bits at position `cnt`.
  - `n = cnt + len_in`; the maximum is 7 + 8 = 15, so there is no overflow and no backpressure.
  - `len_in = 0` is a no-op.
  - `len_in > MAX_LEN`: the codeword is dropped, `err` is set to 1, and `acc`/`cnt` are unchanged.
- **Emit rule (RUN)**
  - If `n ≥ 8`: `out` ← top 8 bits, `valid` ← 1, the accumulator shifts left by 8, `cnt` ← n−8.
  - Otherwise: `cnt` ← n, `valid` ← 0.
- **Flush from RUN**
  - `flush` high is evaluated after the same-cycle codeword has been absorbed, i.e. against `n`.
  - n = 0: `flush_done` ← 1, no byte is emitted.
  - 1 ≤ n ≤ 7: emit the top n bits padded with zeros in the low bits; `valid` ← 1 and `flush_done` ← 1; `cnt` ← 0.
  - n = 8: emit the full byte; `flush_done` ← 1; `cnt` ← 0.
  - n ≥ 9: emit the full byte, `cnt` ← n−8, go to FLUSH.
- **FLUSH state**
  - Emit the remaining 1..7 bits zero-padded, with `valid` and `flush_done` both 1.
  - `cnt` ← 0, return to RUN.
  - `code_valid` and `flush` are ignored while in FLUSH.
- **Reset mid-operation:** buffered bits are discarded; no partial byte is emitted.

## Timing
- **Reset values:** `out` = 0x00, `valid` = 0, `busy` = 0, `flush_done` = 0, `err` = 0. Internally `acc` = 0, `cnt` = 0, state = RUN.
- **Registered outputs:** all outputs are registered. A byte completed by the codeword sampled at edge k appears on `out` with `valid` = 1 after edge k, for exactly one cycle.
- **Latency:** one cycle from the completing codeword to `valid`.
- **Throughput:** sustains one codeword of any length per cycle in RUN, with at most one byte per cycle.
- **Flush timing:** `flush_done` coincides with the last byte's `valid` pulse. If no byte is emitted, it pulses alone one cycle after `flush`. `busy` is high for exactly one cycle when a flush needs two bytes.
- **Output hold:** `out` holds its last value while `valid` = 0.

## Configuration
- Macro `HUFF_PACK_STATS_EN`.
- **Defined:**
  - Adds output port `byte_count`, 16 bits: the number of bytes emitted since reset.
  - Increments on every `valid` pulse, including padded flush bytes, and wraps from 0xFFFF to 0x0000.
  - Reset value 0.
- **Undefined:** the port and counter do not exist, and all other behaviour is identical.

## Test plan
- **Basic packing:** 0b101 (len 3), then 0b11110 (len 5) on consecutive cycles → `out` = 0xBE, `valid` = 1, one cycle after the second codeword; `cnt` returns to 0.
- **Single-bit flush:** codeword 0b1 (len 1) with `flush` in the same cycle → `out` = 0x80, `valid` = 1, `flush_done` = 1 together; no further bytes.
- **Two-byte flush:** 0b1010101 (len 7), then 0xFF (len 8) with `flush` in the same cycle → 0xAB, then on the next cycle 0xFE with `flush_done` = 1; `busy` is high during the second cycle; a `code_valid` asserted then is ignored.
- **Illegal length:** `len_in` = 9 → `err` = 1 (sticky), no `valid`, the accumulator is unchanged. A following 0x3C (len 8) emits 0x3C.
- **Reset mid-operation:** 5 bits buffered, then `rst` asserted low → all outputs at reset values, `flush` emits nothing. After release, 0x3C (len 8) → 0x3C.
- **Stats (with `HUFF_PACK_STATS_EN`):** emit 0x10000 bytes → `byte_count` wraps to 0x0000.
